// File: rtl/lifo_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong LIFO bit-reversal controller.
// Holds the per-bank state encoding, the default block geometry and the
// payload word carried through the output buffer.
package lifo_pingpong_ctrl_pkg;

  localparam int unsigned BLOCK_LEN_DEF = 32;
  localparam int unsigned CNT_W_DEF     = 6;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // One output bit plus its end-of-block marker.
  typedef struct packed {
    logic data;
    logic last;
  } obit_t;

  // A bank may take pushes while it is empty or partially filled.
  function automatic logic bank_writable(input bank_state_e s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

  // A bank may be popped once it holds a complete block.
  function automatic logic bank_readable(input bank_state_e s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/lifo_pingpong_ctrl_out_skid2.sv
// Two-entry output buffer for the reversed bit stream.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_bit / in_ready  write side (bit + last flag)
//   out_valid / out_bit / out_ready  read side, driven from the head register
//   occ                           number of occupied entries (0..2)
module out_skid2
  import lifo_pingpong_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  obit_t      in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output obit_t      out_bit,
  input  logic       out_ready,
  output logic [1:0] occ
);

  obit_t head_q;
  obit_t spare_q;
  logic  head_vld_q;
  logic  spare_vld_q;
  logic  enq;
  logic  deq;

  assign in_ready  = ~spare_vld_q;
  assign enq       = in_valid & ~spare_vld_q;
  assign deq       = head_vld_q & out_ready;
  assign out_valid = head_vld_q;
  assign out_bit   = head_q;
  assign occ       = 2'(head_vld_q) + 2'(spare_vld_q);

  // Head refills from the spare first so ordering is preserved; the spare
  // is only ever occupied while the head is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      spare_q     <= '0;
      head_vld_q  <= 1'b0;
      spare_vld_q <= 1'b0;
    end else if (deq || !head_vld_q) begin
      if (spare_vld_q) begin
        head_q      <= spare_q;
        head_vld_q  <= 1'b1;
        spare_vld_q <= enq;
        if (enq) spare_q <= in_bit;
      end else begin
        head_vld_q <= enq;
        if (enq) head_q <= in_bit;
      end
    end else if (enq) begin
      spare_vld_q <= 1'b1;
      spare_q     <= in_bit;
    end
  end

endmodule

// File: rtl/lifo_pingpong_ctrl.sv
// Ping-pong controller that reverses each block of BLOCK_LEN bits using two
// external LIFO stacks: one bank fills while the other drains.
// Ports:
//   iClk, iRst                    clock, asynchronous active-high reset
//   iData / iValid / oReady       input bit stream
//   oData / oValid / iReady       output bit stream, oLast marks block end
//   oPush / oPop / oStkData       per-bank stack strobes and shared push data
//   iStkData / iStkEmpty / iStkFull  per-bank stack read data and flags
//   oErr                          sticky push-on-full / pop-on-empty flag
module lifo_pingpong_ctrl
  import lifo_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oLast,
  output logic [1:0] oPush,
  output logic [1:0] oPop,
  output logic       oStkData,
  input  logic [1:0] iStkData,
  input  logic [1:0] iStkEmpty,
  input  logic [1:0] iStkFull,
  output logic       oErr
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_LEN);

  bank_state_e      bank_q [2];
  bank_state_e      bank_d [2];
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             ready_en_q;
  logic             inflight_q;
  logic             inflight_bank_q;
  logic             inflight_last_q;
  logic             err_q, err_d;

  logic             push_c;
  logic             pop_c;
  logic [1:0]       credit_c;

  logic             skid_in_ready;
  logic             skid_out_valid;
  obit_t            skid_in_bit;
  obit_t            skid_out_bit;
  logic [1:0]       skid_occ;

  // Next-state and stack strobes. Push only targets a writable bank and pop
  // only a readable one, so the two can never hit the same bank.
  always_comb begin
    bank_d   = bank_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    err_d    = err_q;
    oPush    = 2'b00;
    oPop     = 2'b00;
    oStkData = 1'b0;

    oReady   = ready_en_q & bank_writable(bank_q[wbank_q]);
    push_c   = oReady & iValid;

    // Buffer room counted after this cycle's dequeue keeps 1 bit/cycle.
    credit_c = skid_occ - {1'b0, skid_out_valid & iReady} + {1'b0, inflight_q};
    pop_c    = bank_readable(bank_q[rbank_q]) && (rcnt_q < BLOCK_CNT) &&
               (credit_c < 2'd2);

    if (push_c) begin
      oPush[wbank_q] = 1'b1;
      oStkData       = iData;
      if (wcnt_q == LAST_CNT) begin
        wcnt_d          = '0;
        bank_d[wbank_q] = BANK_FULL;
        wbank_d         = ~wbank_q;
      end else begin
        wcnt_d          = wcnt_q + CNT_W'(1);
        bank_d[wbank_q] = BANK_FILLING;
      end
    end

    if (pop_c) begin
      oPop[rbank_q] = 1'b1;
      if (rcnt_q == LAST_CNT) begin
        rcnt_d          = '0;
        bank_d[rbank_q] = BANK_EMPTY;
        rbank_d         = ~rbank_q;
      end else begin
        rcnt_d          = rcnt_q + CNT_W'(1);
        bank_d[rbank_q] = BANK_DRAINING;
      end
    end

    if ((push_c && iStkFull[wbank_q]) || (pop_c && iStkEmpty[rbank_q])) begin
      err_d = 1'b1;
    end
  end

  // State register; ready_en holds oReady low until the first edge out of reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      bank_q[0]       <= BANK_EMPTY;
      bank_q[1]       <= BANK_EMPTY;
      wbank_q         <= 1'b0;
      rbank_q         <= 1'b0;
      wcnt_q          <= '0;
      rcnt_q          <= '0;
      ready_en_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      bank_q          <= bank_d;
      wbank_q         <= wbank_d;
      rbank_q         <= rbank_d;
      wcnt_q          <= wcnt_d;
      rcnt_q          <= rcnt_d;
      ready_en_q      <= 1'b1;
      inflight_q      <= pop_c;
      inflight_bank_q <= rbank_q;
      inflight_last_q <= (rcnt_q == LAST_CNT);
      err_q           <= err_d;
    end
  end

  // Stack read data arrives the cycle after the pop, from the bank popped.
  assign skid_in_bit.data = iStkData[inflight_bank_q];
  assign skid_in_bit.last = inflight_last_q;

  out_skid2 u_out_skid2 (
    .clk       (iClk),
    .rst       (iRst),
    .in_valid  (inflight_q & skid_in_ready),
    .in_bit    (skid_in_bit),
    .in_ready  (skid_in_ready),
    .out_valid (skid_out_valid),
    .out_bit   (skid_out_bit),
    .out_ready (iReady),
    .occ       (skid_occ)
  );

  assign oValid = skid_out_valid;
  assign oData  = skid_out_bit.data;
  assign oLast  = skid_out_bit.last;
  assign oErr   = err_q;

endmodule

// File: tb/tb_lifo_pingpong_ctrl.sv
// Directed bench for lifo_pingpong_ctrl with two behavioural 32-deep stacks.
module tb_lifo_pingpong_ctrl;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iData = 1'b0;
  logic       iValid = 1'b0;
  logic       iReady = 1'b0;
  logic       oReady, oData, oValid, oLast, oStkData, oErr;
  logic [1:0] oPush, oPop, iStkData, iStkEmpty, iStkFull;

  int n_vec = 0;
  int n_err = 0;

  bit src[$];
  bit exp_q[$];

  int cyc = 0;
  int acc_cnt, acc_rst_cnt, out_cnt, gaps, drops, overlap;
  int last_acc_cyc, first_val_cyc;
  bit out_started, stall_q, data_q, last_q, track;
  bit rand_v, rand_r;
  bit rdy_level = 1'b1;
  bit force_full0 = 1'b0;

  logic [31:0] words [8] = '{32'h8000_0001, 32'hA5A5_5A5A, 32'h0000_FFFF,
                             32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFE,
                             32'h0F0F_3C3C, 32'h7FFF_0000};

  lifo_pingpong_ctrl #(.BLOCK_LEN(32), .CNT_W(6)) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .oReady(oReady),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oLast(oLast),
    .oPush(oPush), .oPop(oPop), .oStkData(oStkData), .iStkData(iStkData),
    .iStkEmpty(iStkEmpty), .iStkFull(iStkFull), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  // Behavioural stacks, read data valid the cycle after a pop.
  logic [31:0] smem [2];
  int          sp [2];
  logic [1:0]  srd;
  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sp[0] <= 0;
      sp[1] <= 0;
      srd   <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (oPush[b] && sp[b] < 32) begin
          smem[b][5'(sp[b])] <= oStkData;
          sp[b] <= sp[b] + 1;
        end else if (oPop[b] && sp[b] > 0) begin
          srd[b] <= smem[b][5'(sp[b] - 1)];
          sp[b]  <= sp[b] - 1;
        end
      end
    end
  end
  assign iStkData  = srd;
  assign iStkEmpty = {sp[1] == 0, sp[0] == 0};
  assign iStkFull  = {sp[1] == 32, (sp[0] == 32) | force_full0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  task automatic ncyc();
    @(negedge iClk);
    #1;
  endtask

  task automatic send_block(input logic [31:0] w);
    for (int i = 0; i < 32; i++) src.push_back(w[i]);
    for (int i = 31; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic clear_sb();
    src.delete();
    exp_q.delete();
    acc_cnt = 0; acc_rst_cnt = 0; out_cnt = 0;
    out_started = 1'b0; stall_q = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge iClk);
    #2;
    iRst = 1'b1;
    clear_sb();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    #1;
    iRst = 1'b0;
    @(posedge iClk);
    #2;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < budget) begin
      ncyc();
      n++;
    end
    chk(tag, 32'(src.size() + exp_q.size()), 32'd0);
    repeat (4) ncyc();
  endtask

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  // Input and output-ready driver, updated just after each rising edge.
  initial forever begin
    @(posedge iClk);
    #1;
    iValid = (src.size() > 0) && (rand_v ? ($urandom_range(0, 1) == 1) : 1'b1);
    iData  = (src.size() > 0) ? src[0] : 1'b0;
    iReady = rand_r ? ($urandom_range(0, 1) == 1) : rdy_level;
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge iClk);
    if (!iRst) begin
      if ((oPush & oPop) != 2'b00) overlap++;
      if (track && src.size() > 0 && !oReady) drops++;
      if (track && out_started && !oValid && exp_q.size() > 0) gaps++;
      if (iValid && oReady) begin
        chk("push_bank", 32'(oPush), ((acc_rst_cnt / 32) % 2 == 1) ? 32'd2 : 32'd1);
        chk("stk_data", 32'(oStkData), 32'(iData));
        if (src.size() > 0) void'(src.pop_front());
        acc_cnt++;
        acc_rst_cnt++;
        if (acc_cnt == 32) last_acc_cyc = cyc;
      end
      if (oValid && !out_started) begin
        out_started   = 1'b1;
        first_val_cyc = cyc;
      end
      if (oValid && stall_q) chk("stall_hold", 32'({oLast, oData}), 32'({last_q, data_q}));
      if (oValid && iReady) begin
        if (exp_q.size() == 0) chk("extra_out", 32'd1, 32'd0);
        else chk("out_data", 32'(oData), 32'(exp_q.pop_front()));
        chk("out_last", 32'(oLast), 32'((out_cnt % 32) == 31));
        out_cnt++;
      end
      stall_q = oValid & ~iReady;
      data_q  = oData;
      last_q  = oLast;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_sb();
    gaps = 0; drops = 0; overlap = 0; track = 1'b0;
    rand_v = 1'b0; rand_r = 1'b0;

    // Reset values and the ready release one edge after deassertion.
    #1 iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #2;
    chk("rst_oReady", 32'(oReady), 32'd0);
    chk("rst_oValid", 32'(oValid), 32'd0);
    chk("rst_oData", 32'(oData), 32'd0);
    chk("rst_oLast", 32'(oLast), 32'd0);
    chk("rst_oPush", 32'(oPush), 32'd0);
    chk("rst_oPop", 32'(oPop), 32'd0);
    chk("rst_oStkData", 32'(oStkData), 32'd0);
    chk("rst_oErr", 32'(oErr), 32'd0);
    @(negedge iClk);
    #1 iRst = 1'b0;
    chk("rel_ready_low", 32'(oReady), 32'd0);
    @(posedge iClk);
    #1 chk("rel_ready_high", 32'(oReady), 32'd1);

    // Single block, latency from last accept to first valid.
    ncyc();
    acc_cnt = 0; out_cnt = 0; out_started = 1'b0;
    send_block(words[0]);
    wait_drain(300, "blk1_drain");
    chk("blk1_latency", 32'(first_val_cyc - last_acc_cyc), 32'd3);
    chk("blk1_count", 32'(out_cnt), 32'd32);

    // Three back-to-back blocks: no ready drop, no output gaps.
    acc_cnt = 0; out_cnt = 0; out_started = 1'b0;
    gaps = 0; drops = 0; track = 1'b1;
    send_block(words[1]); send_block(words[2]); send_block(words[3]);
    wait_drain(400, "blk3_drain");
    track = 1'b0;
    chk("blk3_ready_drops", 32'(drops), 32'd0);
    chk("blk3_gaps", 32'(gaps), 32'd0);
    chk("blk3_count", 32'(out_cnt), 32'd96);

    // Output stalled: both banks fill, ready drops after 64 bits.
    acc_cnt = 0; out_cnt = 0; out_started = 1'b0;
    rdy_level = 1'b0;
    send_block(words[4]); send_block(words[5]); send_block(words[6]);
    n = 0;
    while (oReady && n < 200) begin ncyc(); n++; end
    chk("full_ready_low", 32'(oReady), 32'd0);
    chk("full_accepts", 32'(acc_cnt), 32'd64);
    repeat (5) ncyc();
    chk("full_ready_held", 32'(oReady), 32'd0);
    chk("full_accepts_held", 32'(acc_cnt), 32'd64);
    rdy_level = 1'b1;
    n = 0;
    while (!oReady && n < 100) begin ncyc(); n++; end
    chk("full_ready_back", 32'(oReady), 32'd1);
    wait_drain(400, "full_drain");
    chk("full_count", 32'(out_cnt), 32'd96);

    // Random handshakes on both sides over 20 blocks.
    acc_cnt = 0; out_cnt = 0; out_started = 1'b0;
    rand_v = 1'b1; rand_r = 1'b1;
    for (int k = 0; k < 20; k++) send_block(words[k % 8] ^ {16'(k), 16'(k * 7)});
    wait_drain(8000, "rand_drain");
    rand_v = 1'b0; rand_r = 1'b0;
    ncyc();
    chk("rand_count", 32'(out_cnt), 32'd640);

    // Reset in the middle of a drain.
    acc_cnt = 0; out_cnt = 0; out_started = 1'b0;
    send_block(words[3]);
    n = 0;
    while (out_cnt < 10 && n < 200) begin ncyc(); n++; end
    chk("mid_reached", 32'(out_cnt), 32'd10);
    @(posedge iClk);
    #2 iRst = 1'b1;
    #1;
    chk("mid_oValid", 32'(oValid), 32'd0);
    chk("mid_oData", 32'(oData), 32'd0);
    chk("mid_oLast", 32'(oLast), 32'd0);
    chk("mid_oPop", 32'(oPop), 32'd0);
    chk("mid_oPush", 32'(oPush), 32'd0);
    chk("mid_oReady", 32'(oReady), 32'd0);
    clear_sb();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    #1 iRst = 1'b0;
    @(posedge iClk);
    #1 chk("mid_ready_back", 32'(oReady), 32'd1);
    ncyc();
    send_block(words[7]);
    wait_drain(300, "mid_next_drain");
    chk("mid_next_count", 32'(out_cnt), 32'd32);

    // Push into a full-flagged stack raises the sticky error.
    do_reset();
    force_full0 = 1'b1;
    src.push_back(1'b1);
    n = 0;
    while (acc_cnt < 1 && n < 20) begin ncyc(); n++; end
    chk("err_pushed", 32'(acc_cnt), 32'd1);
    chk("err_pre", 32'(oErr), 32'd0);
    ncyc();
    force_full0 = 1'b0;
    chk("err_set", 32'(oErr), 32'd1);
    repeat (5) ncyc();
    chk("err_sticky", 32'(oErr), 32'd1);
    do_reset();
    chk("err_clear", 32'(oErr), 32'd0);

    chk("push_pop_same_bank", 32'(overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
